// File: rtl/ama_riscv_imm_gen_pipe_pkg.sv
// Shared decode defines for the AMA-RISCV immediate generator:
// immediate-select encodings and legal-parameter helpers.
package ama_riscv_imm_gen_pipe_pkg;

    // Immediate type select carried from the decoder
    typedef enum logic [2:0] {
        IgDisabled = 3'b000,
        IgIType    = 3'b001,
        IgSType    = 3'b010,
        IgBType    = 3'b011,
        IgJType    = 3'b100,
        IgUType    = 3'b101,
        IgZType    = 3'b110,
        IgRsvd     = 3'b111
    } ig_sel_e;

    // Width of the instruction slice ins[31:7] fed to the generator
    localparam int unsigned IgInW = 25;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit stages_legal(input int unsigned stages);
        return (stages >= 1) && (stages <= 3);
    endfunction

endpackage

// File: rtl/ama_riscv_imm_expand.sv
// Combinational immediate expansion: decodes ig_sel, sign/zero-extends the
// selected immediate to XLEN, and reports whether the hold value must update.
module ama_riscv_imm_expand
    import ama_riscv_imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]       ig_sel_i,
    input  logic [IgInW-1:0] ig_in_i,
    input  logic [XLEN-1:0]  hold_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             err_o,
    output logic             upd_hold_o
);

    // ig_in_i[n] holds instruction bit n+7
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    logic        [4:0]  imm_z;

    assign imm_i = ig_in_i[24:13];
    assign imm_s = {ig_in_i[24:18], ig_in_i[4:0]};
    assign imm_b = {ig_in_i[24], ig_in_i[0], ig_in_i[23:18], ig_in_i[4:1], 1'b0};
    assign imm_j = {ig_in_i[24], ig_in_i[12:5], ig_in_i[13], ig_in_i[23:14], 1'b0};
    assign imm_u = {ig_in_i[24:5], 12'b0};
    assign imm_z = ig_in_i[12:8];

    // Select and extend; signed casts sign-extend from ins[31]
    always_comb begin
        imm_o      = '0;
        err_o      = 1'b0;
        upd_hold_o = 1'b0;
        unique case (ig_sel_e'(ig_sel_i))
            IgDisabled: imm_o = hold_i;
            IgIType: begin
                imm_o      = XLEN'(imm_i);
                upd_hold_o = 1'b1;
            end
            IgSType: begin
                imm_o      = XLEN'(imm_s);
                upd_hold_o = 1'b1;
            end
            IgBType: begin
                imm_o      = XLEN'(imm_b);
                upd_hold_o = 1'b1;
            end
            IgJType: begin
                imm_o      = XLEN'(imm_j);
                upd_hold_o = 1'b1;
            end
            IgUType: begin
                imm_o      = XLEN'(imm_u);
                upd_hold_o = 1'b1;
            end
            IgZType: begin
                imm_o      = XLEN'(imm_z);
                upd_hold_o = 1'b1;
            end
            IgRsvd: begin
                imm_o = '0;
                err_o = 1'b1;
            end
            default: begin
                imm_o = '0;
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ama_riscv_imm_gen_pipe.sv
// Pipelined immediate generator: expands at acceptance into stage 0, then moves
// entries through STAGES elastic valid/ready registers with flush. A hold
// register supplies the value returned for DISABLED entries.
module ama_riscv_imm_gen_pipe
    import ama_riscv_imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       ig_sel_i,
    input  logic [IgInW-1:0] ig_in_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  ig_out_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_err_o
);

    if (!xlen_legal(XLEN) || !stages_legal(STAGES)) begin : g_param_check
        $error("ama_riscv_imm_gen_pipe: illegal XLEN or STAGES");
    end

    logic              en_q;
    logic [XLEN-1:0]   hold_q;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] stage_rdy;
    logic [STAGES-1:0] vmask;
    logic [XLEN-1:0]   exp_imm;
    logic              exp_err;
    logic              exp_upd;
    logic              accept;

    ama_riscv_imm_expand #(
        .XLEN (XLEN)
    ) u_expand (
        .ig_sel_i   (ig_sel_i),
        .ig_in_i    (ig_in_i),
        .hold_i     (hold_q),
        .imm_o      (exp_imm),
        .err_o      (exp_err),
        .upd_hold_o (exp_upd)
    );

    // Stage k can take a new entry if it or any later stage is empty, or the
    // consumer drains the last stage; closed form avoids a combinational chain.
    always_comb begin
        stage_rdy = '0;
        vmask     = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            vmask        = valid_q | STAGES'((32'd1 << k) - 32'd1);
            stage_rdy[k] = out_ready_i || !(&vmask);
        end
    end

    // en_q keeps in_ready low until the first edge after reset release
    assign in_ready_o = en_q && !flush_i && stage_rdy[0];
    assign accept     = in_valid_i && in_ready_o;

    // Valid bits: shift where a stage is ready, clear everything on flush
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (stage_rdy[0]) valid_d[0] = accept;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (stage_rdy[k]) valid_d[k] = valid_q[k-1];
            end
        end
    end

    // Valid bits and the post-reset enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            en_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            en_q    <= 1'b1;
        end
    end

    // Hold register tracks the latest accepted non-DISABLED, non-reserved entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (accept && exp_upd) begin
            hold_q <= exp_imm;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             ld;
        logic [XLEN-1:0]  imm_d;
        logic [XLEN-1:0]  imm_q;
        logic [TAG_W-1:0] tag_d;
        logic [TAG_W-1:0] tag_q;
        logic             err_d;
        logic             err_q;

        if (k == 0) begin : g_head
            assign ld    = accept;
            assign imm_d = exp_imm;
            assign tag_d = in_tag_i;
            assign err_d = exp_err;
        end else begin : g_body
            assign ld    = !flush_i && stage_rdy[k] && valid_q[k-1];
            assign imm_d = g_stage[k-1].imm_q;
            assign tag_d = g_stage[k-1].tag_q;
            assign err_d = g_stage[k-1].err_q;
        end

        // Stage payload loads only when a valid entry moves in
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                imm_q <= '0;
                tag_q <= '0;
                err_q <= 1'b0;
            end else if (ld) begin
                imm_q <= imm_d;
                tag_q <= tag_d;
                err_q <= err_d;
            end
        end
    end

    assign out_valid_o = valid_q[STAGES-1];
    assign ig_out_o    = g_stage[STAGES-1].imm_q;
    assign out_tag_o   = g_stage[STAGES-1].tag_q;
    assign out_err_o   = g_stage[STAGES-1].err_q;

endmodule

// File: tb/tb_ama_riscv_imm_gen_pipe.sv
// Bench: two instances (XLEN=32/STAGES=1 and XLEN=64/STAGES=3) share stimulus.
// Expected values come from a hand-computed vector table fed to per-DUT queues.
module tb_ama_riscv_imm_gen_pipe;

    localparam int unsigned TagW = 5;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            flush  = 1'b0;
    logic [2:0]      sel    = '0;
    logic [24:0]     ig_in  = '0;
    logic [TagW-1:0] tag    = '0;
    logic            va     = 1'b0;
    logic            vb     = 1'b0;
    logic            ordy_a = 1'b1;
    logic            ordy_b = 1'b1;

    logic            rdy_a, rdy_b, ova, ovb, erra, errb;
    logic [31:0]     outa;
    logic [63:0]     outb;
    logic [TagW-1:0] taga, tagb;

    always #5 clk = ~clk;

    ama_riscv_imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(TagW)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(va), .in_ready_o(rdy_a),
        .ig_sel_i(sel), .ig_in_i(ig_in), .in_tag_i(tag), .out_valid_o(ova),
        .out_ready_i(ordy_a), .ig_out_o(outa), .out_tag_o(taga), .out_err_o(erra)
    );

    ama_riscv_imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(TagW)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(vb), .in_ready_o(rdy_b),
        .ig_sel_i(sel), .ig_in_i(ig_in), .in_tag_i(tag), .out_valid_o(ovb),
        .out_ready_i(ordy_b), .ig_out_o(outb), .out_tag_o(tagb), .out_err_o(errb)
    );

    typedef struct {
        logic [2:0]      sel;
        logic [31:0]     instr;
        logic [TagW-1:0] tag;
        logic [63:0]     exp;
        logic            err;
    } vec_t;

    typedef struct {
        logic [63:0]     imm;
        logic [TagW-1:0] tag;
        logic            err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[15];
    int   checks = 0;
    int   errors = 0;
    bit   bp_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [31:0] ins,
                                input logic [TagW-1:0] t, input logic [63:0] e, input logic er);
        vec_t v;
        v.sel = s; v.instr = ins; v.tag = t; v.exp = e; v.err = er;
        return v;
    endfunction

    // Present one entry to the selected DUTs until each has accepted it
    task automatic send(input vec_t v, input bit to_a, input bit to_b);
        bit   da = !to_a;
        bit   db = !to_b;
        bit   aa, ab;
        int   c = 0;
        exp_t e;
        e.imm = v.exp; e.tag = v.tag; e.err = v.err;
        while (!(da && db)) begin
            @(negedge clk);
            sel = v.sel; ig_in = v.instr[31:7]; tag = v.tag;
            va = !da; vb = !db;
            #1;
            aa = va && rdy_a;
            ab = vb && rdy_b;
            @(posedge clk);
            if (aa) begin qa.push_back(e); da = 1'b1; end
            if (ab) begin qb.push_back(e); db = 1'b1; end
            c++;
            if (c > 40) begin
                checks++; errors++;
                $display("FAIL send_timeout: tag %0d not accepted (a=%0b b=%0b)", v.tag, da, db);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 30 && (qa.size() != 0 || qb.size() != 0); c++) @(negedge clk);
        chk({name, "_a_left"}, 64'(qa.size()), 64'd0);
        chk({name, "_b_left"}, 64'(qb.size()), 64'd0);
    endtask

    // Output monitor: compare each transfer against the queues, check stalls
    bit              stall_a = 1'b0, stall_b = 1'b0;
    logic [31:0]     held_a;
    logic [63:0]     held_b;
    logic [TagW-1:0] held_ta, held_tb;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n || flush) begin
            stall_a = 1'b0; stall_b = 1'b0;
        end else begin
            if (vb && !rdy_b && !bp_seen) begin
                bp_seen = 1'b1;
                chk("b_full_depth", 64'(qb.size()), 64'd3);
            end
            if (stall_a && ova) begin
                chk("a_stable_imm", 64'(outa), 64'(held_a));
                chk("a_stable_tag", 64'(taga), 64'(held_ta));
            end
            if (stall_b && ovb) begin
                chk("b_stable_imm", outb, held_b);
                chk("b_stable_tag", 64'(tagb), 64'(held_tb));
            end
            if (ova && ordy_a) begin
                if (qa.size() == 0) chk("a_spurious_out", 64'(ova), 64'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_imm", 64'(outa), 64'(e.imm[31:0]));
                    chk("a_tag", 64'(taga), 64'(e.tag));
                    chk("a_err", 64'(erra), 64'(e.err));
                end
            end
            if (ovb && ordy_b) begin
                if (qb.size() == 0) chk("b_spurious_out", 64'(ovb), 64'd0);
                else begin
                    e = qb.pop_front();
                    chk("b_imm", outb, e.imm);
                    chk("b_tag", 64'(tagb), 64'(e.tag));
                    chk("b_err", 64'(errb), 64'(e.err));
                end
            end
            stall_a = ova && !ordy_a; held_a = outa; held_ta = taga;
            stall_b = ovb && !ordy_b; held_b = outb; held_tb = tagb;
        end
    end

    initial begin
        tbl[0]  = mk(3'b001, 32'hFFF00093, 5'd1,  64'hFFFFFFFFFFFFFFFF, 1'b0);
        tbl[1]  = mk(3'b010, 32'hFE20AE23, 5'd2,  64'hFFFFFFFFFFFFFFFC, 1'b0);
        tbl[2]  = mk(3'b011, 32'hFE000CE3, 5'd3,  64'hFFFFFFFFFFFFFFF8, 1'b0);
        tbl[3]  = mk(3'b100, 32'h0010006F, 5'd4,  64'h0000000000000800, 1'b0);
        tbl[4]  = mk(3'b110, 32'h000FD073, 5'd5,  64'h000000000000001F, 1'b0);
        tbl[5]  = mk(3'b101, 32'h800000B7, 5'd6,  64'hFFFFFFFF80000000, 1'b0);
        tbl[6]  = mk(3'b000, 32'h12345678, 5'd7,  64'hFFFFFFFF80000000, 1'b0);
        tbl[7]  = mk(3'b111, 32'hFFFFFFFF, 5'd8,  64'h0000000000000000, 1'b1);
        tbl[8]  = mk(3'b000, 32'h00000000, 5'd9,  64'hFFFFFFFF80000000, 1'b0);
        tbl[9]  = mk(3'b001, 32'h7FF00013, 5'd10, 64'h00000000000007FF, 1'b0);
        tbl[10] = mk(3'b000, 32'hFFFFFFFF, 5'd11, 64'h00000000000007FF, 1'b0);
        tbl[11] = mk(3'b101, 32'h12345037, 5'd12, 64'h0000000012345000, 1'b0);
        tbl[12] = mk(3'b110, 32'h80078073, 5'd13, 64'h000000000000000F, 1'b0);
        tbl[13] = mk(3'b100, 32'hFFFFF06F, 5'd14, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        tbl[14] = mk(3'b011, 32'h00000863, 5'd15, 64'h0000000000000010, 1'b0);

        // Reset state
        #12;
        chk("rst_a_valid", 64'(ova), 64'd0);
        chk("rst_a_imm",   64'(outa), 64'd0);
        chk("rst_a_tag",   64'(taga), 64'd0);
        chk("rst_a_err",   64'(erra), 64'd0);
        chk("rst_b_valid", 64'(ovb), 64'd0);
        chk("rst_b_imm",   outb, 64'd0);
        chk("rst_a_ready", 64'(rdy_a), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        chk("post_rst_a_ready", 64'(rdy_a), 64'd1);
        chk("post_rst_b_ready", 64'(rdy_b), 64'd1);

        // Latency: STAGES=1 next cycle, STAGES=3 three cycles after acceptance
        send(tbl[0], 1'b1, 1'b1);
        idle(); #1;
        chk("lat_a_valid", 64'(ova), 64'd1);
        chk("lat_a_imm",   64'(outa), 64'hFFFFFFFF);
        chk("lat_a_tag",   64'(taga), 64'd1);
        chk("lat_b_valid1", 64'(ovb), 64'd0);
        @(negedge clk); #1;
        chk("lat_b_valid2", 64'(ovb), 64'd0);
        @(negedge clk); #1;
        chk("lat_b_valid3", 64'(ovb), 64'd1);
        chk("lat_b_imm",    outb, 64'hFFFFFFFFFFFFFFFF);
        drain("latency");

        // Back-to-back table stream
        for (int i = 1; i < 15; i++) send(tbl[i], 1'b1, 1'b1);
        idle();
        drain("table");

        // Backpressure on the 3-stage instance, 6 entries, 4 stalled cycles
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(mk(3'b001, (32'(i + 1) << 20) | 32'h13, 5'(16 + i),
                            64'(i + 1), 1'b0), 1'b1, 1'b1);
                idle();
            end
            begin
                repeat (2) @(negedge clk);
                ordy_b = 1'b0;
                repeat (4) @(negedge clk);
                ordy_b = 1'b1;
            end
        join
        drain("bp");
        chk("bp_in_ready_dropped", 64'(bp_seen), 64'd1);

        // Flush with three in flight plus a valid input
        ordy_b = 1'b0;
        send(mk(3'b001, 32'h02100013, 5'd22, 64'h21, 1'b0), 1'b0, 1'b1);
        send(mk(3'b001, 32'h02200013, 5'd23, 64'h22, 1'b0), 1'b0, 1'b1);
        send(mk(3'b001, 32'h02300013, 5'd24, 64'h23, 1'b0), 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b1; sel = 3'b101; ig_in = 25'(32'h7FFFF037 >> 7); tag = 5'd25; vb = 1'b1;
        #1;
        chk("flush_in_ready", 64'(rdy_b), 64'd0);
        @(negedge clk);
        flush = 1'b0; vb = 1'b0;
        #1;
        chk("flush_b_valid", 64'(ovb), 64'd0);
        qb.delete();
        ordy_b = 1'b1;
        send(mk(3'b000, 32'h0, 5'd26, 64'h23, 1'b0), 1'b0, 1'b1);
        idle();
        drain("flush");

        // Asynchronous reset mid-operation with full pipes
        ordy_a = 1'b0; ordy_b = 1'b0;
        send(mk(3'b001, 32'h05500013, 5'd27, 64'h55, 1'b0), 1'b1, 1'b1);
        send(mk(3'b001, 32'h05600013, 5'd28, 64'h56, 1'b0), 1'b0, 1'b1);
        send(mk(3'b001, 32'h05700013, 5'd29, 64'h57, 1'b0), 1'b0, 1'b1);
        @(negedge clk); vb = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_a_valid", 64'(ova), 64'd0);
        chk("arst_a_imm",   64'(outa), 64'd0);
        chk("arst_a_tag",   64'(taga), 64'd0);
        chk("arst_b_valid", 64'(ovb), 64'd0);
        chk("arst_b_imm",   outb, 64'd0);
        chk("arst_b_tag",   64'(tagb), 64'd0);
        chk("arst_b_ready", 64'(rdy_b), 64'd0);
        qa.delete(); qb.delete();
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rel_b_ready_pre_edge", 64'(rdy_b), 64'd0);
        ordy_a = 1'b1; ordy_b = 1'b1;
        send(mk(3'b000, 32'hFFFFFFFF, 5'd30, 64'h0, 1'b0), 1'b1, 1'b1);
        idle();
        drain("reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL global_timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
